// File: rtl/fruta_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fruta_gen_pkg
// Purpose  : Shared map cell codes, default map size, LFSR seed and FSM codes.
// Revision : 1.0 - initial release
// ============================================================================
package fruta_gen_pkg;

    localparam logic [1:0] c_cell_empty    = 2'b00;
    localparam logic [1:0] c_cell_snake    = 2'b01;
    localparam logic [1:0] c_cell_fruit    = 2'b10;
    localparam logic [1:0] c_cell_obstacle = 2'b11;

    localparam int c_mapa_width_def  = 40;
    localparam int c_mapa_height_def = 30;

    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    localparam logic [2:0] c_st_reset      = 3'd0;
    localparam logic [2:0] c_st_gen        = 3'd1;
    localparam logic [2:0] c_st_read       = 3'd2;
    localparam logic [2:0] c_st_check      = 3'd3;
    localparam logic [2:0] c_st_ready      = 3'd4;
    localparam logic [2:0] c_st_scan_read  = 3'd5;
    localparam logic [2:0] c_st_scan_check = 3'd6;
    localparam logic [2:0] c_st_full       = 3'd7;

    // Fibonacci step, taps 16,14,13,11 counted from the output bit (bit 0).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] w_n;
        w_n = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return (w_n == 16'd0) ? c_lfsr_seed : w_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fruta_gen_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Fibonacci LFSR that steps only when advance is high.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
    import fruta_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= c_lfsr_seed;
        end else if (advance) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/fruta_gen.sv
`default_nettype none
// ============================================================================
// Module   : fruta_gen
// Purpose  : Picks a free map cell for the next fruit: random probes first,
//            then a row-major scan; keeps re-validating the held cell.
// Revision : 1.0 - initial release
// ============================================================================
module fruta_gen
    import fruta_gen_pkg::*;
#(
    parameter int MAPA_WIDTH  = c_mapa_width_def,
    parameter int MAPA_HEIGHT = c_mapa_height_def,
    parameter int MAX_TRIES   = 64,
    parameter int INIT_X      = 13,
    parameter int INIT_Y      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fruta_enable,
    output logic [9:0] fruta_wx,
    output logic [9:0] fruta_wy,
    output logic       fruta_wenable,
    output logic       fruta_valid,
    output logic       fruta_full,
    output logic       fruta_renable,
    output logic [9:0] fruta_rx,
    output logic [9:0] fruta_ry,
    input  logic [1:0] fruta_rdata
);

    localparam logic [9:0] c_width     = 10'(MAPA_WIDTH);
    localparam logic [9:0] c_height    = 10'(MAPA_HEIGHT);
    localparam logic [9:0] c_last_x    = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0] c_last_y    = 10'(MAPA_HEIGHT - 1);
    localparam logic [9:0] c_init_x    = 10'(INIT_X);
    localparam logic [9:0] c_init_y    = 10'(INIT_Y);
    localparam logic [6:0] c_max_tries = 7'(MAX_TRIES);

    logic [2:0]  r_state, w_state_next;
    logic [6:0]  r_tries, w_tries_next, w_tries_inc;
    logic [9:0]  r_rx, w_rx_next, r_ry, w_ry_next;
    logic [9:0]  r_wx, w_wx_next, r_wy, w_wy_next;
    logic        r_wenable, w_wenable_next;
    logic        r_valid, w_valid_next;
    logic        r_full, w_full_next;
    logic        r_ready_ph, w_ph_next;
    logic        w_renable, w_load;
    logic [15:0] w_lfsr;
    logic [9:0]  w_cand_x, w_cand_y;
    logic        w_cand_ok, w_cell_free;
    logic        w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (r_state == c_st_gen),
        .value   (w_lfsr)
    );

    assign w_cand_x      = {4'd0, w_lfsr[5:0]};
    assign w_cand_y      = {5'd0, w_lfsr[12:8]};
    assign w_cand_ok     = (w_cand_x < c_width) && (w_cand_y < c_height);
    assign w_cell_free   = (fruta_rdata == c_cell_empty);
    assign w_tries_inc   = (r_tries == 7'h7F) ? r_tries : r_tries + 7'd1;
    assign w_unused_lfsr = ^{w_lfsr[15:13], w_lfsr[7:6]};

    always_comb begin
        w_state_next   = r_state;
        w_tries_next   = r_tries;
        w_rx_next      = r_rx;
        w_ry_next      = r_ry;
        w_wx_next      = r_wx;
        w_wy_next      = r_wy;
        w_wenable_next = 1'b0;
        w_valid_next   = r_valid;
        w_full_next    = r_full;
        w_ph_next      = 1'b0;
        w_renable      = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            c_st_reset: w_state_next = c_st_gen;
            c_st_gen: begin
                if (w_cand_ok) begin
                    w_rx_next    = w_cand_x;
                    w_ry_next    = w_cand_y;
                    w_state_next = c_st_read;
                end
            end
            c_st_read: begin
                w_renable    = 1'b1;
                w_state_next = c_st_check;
            end
            c_st_check: begin
                if (w_cell_free) begin
                    w_load = 1'b1;
                end else begin
                    w_tries_next = w_tries_inc;
                    if (w_tries_inc >= c_max_tries) begin
                        w_rx_next    = 10'd0;
                        w_ry_next    = 10'd0;
                        w_state_next = c_st_scan_read;
                    end else begin
                        w_state_next = c_st_gen;
                    end
                end
            end
            c_st_ready: begin
                // rx/ry still hold the validated cell, so probe it on even phases.
                w_ph_next = ~r_ready_ph;
                if (!r_ready_ph) begin
                    w_renable = 1'b1;
                end else if (!w_cell_free) begin
                    w_valid_next = 1'b0;
                    w_state_next = c_st_gen;
                end
            end
            c_st_scan_read: begin
                w_renable    = 1'b1;
                w_state_next = c_st_scan_check;
            end
            c_st_scan_check: begin
                if (w_cell_free) begin
                    w_load = 1'b1;
                end else if (r_rx == c_last_x && r_ry == c_last_y) begin
                    w_full_next  = 1'b1;
                    w_valid_next = 1'b0;
                    w_state_next = c_st_full;
                end else begin
                    if (r_rx == c_last_x) begin
                        w_rx_next = 10'd0;
                        w_ry_next = r_ry + 10'd1;
                    end else begin
                        w_rx_next = r_rx + 10'd1;
                    end
                    w_state_next = c_st_scan_read;
                end
            end
            c_st_full: ;
            default: w_state_next = c_st_reset;
        endcase

        if (w_load) begin
            w_wx_next      = r_rx;
            w_wy_next      = r_ry;
            w_wenable_next = 1'b1;
            w_valid_next   = 1'b1;
            w_full_next    = 1'b0;
            w_tries_next   = 7'd0;
            w_state_next   = c_st_ready;
        end

        // A consumer request overrides whatever this cycle would have done.
        if (fruta_enable && r_state != c_st_reset) begin
            w_state_next   = c_st_gen;
            w_valid_next   = 1'b0;
            w_full_next    = 1'b0;
            w_wx_next      = r_wx;
            w_wy_next      = r_wy;
            w_wenable_next = 1'b0;
            w_tries_next   = r_tries;
            w_ph_next      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_reset;
            r_tries    <= 7'd0;
            r_rx       <= 10'd0;
            r_ry       <= 10'd0;
            r_wx       <= c_init_x;
            r_wy       <= c_init_y;
            r_wenable  <= 1'b0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_ready_ph <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tries    <= w_tries_next;
            r_rx       <= w_rx_next;
            r_ry       <= w_ry_next;
            r_wx       <= w_wx_next;
            r_wy       <= w_wy_next;
            r_wenable  <= w_wenable_next;
            r_valid    <= w_valid_next;
            r_full     <= w_full_next;
            r_ready_ph <= w_ph_next;
        end
    end

    assign fruta_wx      = r_wx;
    assign fruta_wy      = r_wy;
    assign fruta_wenable = r_wenable;
    assign fruta_valid   = r_valid;
    assign fruta_full    = r_full;
    assign fruta_renable = w_renable;
    assign fruta_rx      = r_rx;
    assign fruta_ry      = r_ry;

endmodule
`default_nettype wire

// File: tb/tb_fruta_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fruta_gen
// Purpose  : Map model plus an algorithmic reference for fruit placement.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fruta_gen;
    import fruta_gen_pkg::*;

    localparam int c_w         = 40;
    localparam int c_h         = 30;
    localparam int c_max_tries = 64;
    localparam int c_budget    = 6000;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       fruta_enable = 1'b0;
    logic [9:0] fruta_wx, fruta_wy, fruta_rx, fruta_ry;
    logic       fruta_wenable, fruta_valid, fruta_full, fruta_renable;
    logic [1:0] fruta_rdata  = 2'b00;

    logic [1:0]  map [c_w][c_h];
    int          n_assert  = 0;
    int          n_fail    = 0;
    int          occ_total = 0;
    logic        rst_q     = 1'b1;
    logic [9:0]  prev_wx   = 10'd13;
    logic [9:0]  prev_wy   = 10'd13;
    logic [15:0] m_lfsr;
    int          m_tries;
    int          first_x, first_y;

    fruta_gen dut (
        .clk           (clk),
        .reset         (reset),
        .fruta_enable  (fruta_enable),
        .fruta_wx      (fruta_wx),
        .fruta_wy      (fruta_wy),
        .fruta_wenable (fruta_wenable),
        .fruta_valid   (fruta_valid),
        .fruta_full    (fruta_full),
        .fruta_renable (fruta_renable),
        .fruta_rx      (fruta_rx),
        .fruta_ry      (fruta_ry),
        .fruta_rdata   (fruta_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] cell_at(input int x, input int y);
        if (x < 0 || x >= c_w || y < 0 || y >= c_h) return c_cell_obstacle;
        return map[x][y];
    endfunction

    // Map memory: one-cycle read latency; also counts probes of occupied cells.
    always @(posedge clk) begin
        rst_q <= reset;
        if (fruta_renable) begin
            fruta_rdata <= cell_at(int'(fruta_rx), int'(fruta_ry));
            if (cell_at(int'(fruta_rx), int'(fruta_ry)) != c_cell_empty)
                occ_total <= occ_total + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every wait goes through here so the held cell is watched on each cycle.
    task automatic tick();
        @(negedge clk);
        if (!rst_q) begin
            check("wxy_change_without_wenable",
                  int'((fruta_wx != prev_wx || fruta_wy != prev_wy) && !fruta_wenable), 0);
            if (fruta_wenable) check("valid_with_wenable", int'(fruta_valid), 1);
        end
        prev_wx = fruta_wx;
        prev_wy = fruta_wy;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    task automatic fill_map(input logic [1:0] code);
        for (int x = 0; x < c_w; x++)
            for (int y = 0; y < c_h; y++)
                map[x][y] = code;
    endtask

    // Reference: one LFSR value per GEN cycle, random probes, then row-major scan.
    task automatic model_search(output int ex, output int ey, output int efull,
                                output int lat, output int occ);
        int k, p, s, x, y;
        bit stop;
        logic [15:0] v;
        k = 0; p = 0; s = 0; stop = 0;
        ex = -1; ey = -1; efull = 0; occ = 0;
        while (!stop) begin
            v = m_lfsr;
            m_lfsr = lfsr_step(v);
            k++;
            x = int'(v[5:0]);
            y = int'(v[12:8]);
            if (x < c_w && y < c_h) begin
                p++;
                if (map[x][y] == c_cell_empty) begin
                    ex = x; ey = y; m_tries = 0; stop = 1;
                end else begin
                    occ++;
                    if (m_tries < 127) m_tries++;
                    if (m_tries >= c_max_tries) begin
                        for (int yy = 0; yy < c_h && !stop; yy++)
                            for (int xx = 0; xx < c_w && !stop; xx++) begin
                                s++;
                                if (map[xx][yy] == c_cell_empty) begin
                                    ex = xx; ey = yy; m_tries = 0; stop = 1;
                                end else begin
                                    occ++;
                                end
                            end
                        if (!stop) begin
                            efull = 1; stop = 1;
                        end
                    end
                end
            end
        end
        lat = 1 + k + 2 * (p + s);
    endtask

    // mode 0: release reset, 1: pulse fruta_enable, 2: search already started.
    task automatic run_search(input int mode, input string tag);
        int ex, ey, efull, lat, occ, n, occ_base;
        bit done;
        logic [9:0] ox, oy;
        model_search(ex, ey, efull, lat, occ);
        ox = fruta_wx;
        oy = fruta_wy;
        done = 0;
        n = 0;
        occ_base = occ_total;
        if (mode == 0) reset = 1'b0;
        else if (mode == 1) fruta_enable = 1'b1;
        else n = 1;
        while (!done && n < c_budget) begin
            tick();
            fruta_enable = 1'b0;
            n++;
            if (n == 1) occ_base = occ_total;
            if (n <= 3) begin
                check({tag, "_hold_x"}, int'(fruta_wx), int'(ox));
                check({tag, "_hold_y"}, int'(fruta_wy), int'(oy));
            end
            if (mode == 1 && n == 1) check({tag, "_valid_cleared"}, int'(fruta_valid), 0);
            if (fruta_wenable || fruta_full) done = 1;
        end
        check({tag, "_done_in_budget"}, int'(done), 1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_full"}, int'(fruta_full), efull);
        check({tag, "_occupied_probes"}, occ_total - occ_base, occ);
        if (efull != 0) begin
            check({tag, "_valid_when_full"}, int'(fruta_valid), 0);
        end else begin
            check({tag, "_x"}, int'(fruta_wx), ex);
            check({tag, "_y"}, int'(fruta_wy), ey);
            check({tag, "_valid"}, int'(fruta_valid), 1);
        end
    endtask

    initial begin
        int n, base;
        logic [9:0] ox, oy;

        fill_map(c_cell_empty);
        m_lfsr  = c_lfsr_seed;
        m_tries = 0;
        reset   = 1'b1;
        repeat (3) tick();
        check("rst_wx", int'(fruta_wx), 13);
        check("rst_wy", int'(fruta_wy), 13);
        check("rst_valid", int'(fruta_valid), 0);
        check("rst_full", int'(fruta_full), 0);
        check("rst_wenable", int'(fruta_wenable), 0);
        check("rst_renable", int'(fruta_renable), 0);
        check("rst_rx", int'(fruta_rx), 0);
        check("rst_ry", int'(fruta_ry), 0);

        run_search(0, "first");
        first_x = int'(fruta_wx);
        first_y = int'(fruta_wy);

        // Random occupancy; the consumed cell becomes snake.
        for (int i = 0; i < 5; i++) begin
            for (int x = 0; x < c_w; x++)
                for (int y = 0; y < c_h; y++)
                    map[x][y] = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : c_cell_empty;
            ox = fruta_wx;
            oy = fruta_wy;
            map[ox][oy] = c_cell_snake;
            run_search(1, "rand");
            check("rand_new_cell", int'(fruta_wx != ox || fruta_wy != oy), 1);
        end

        // Held cell gets occupied behind the generator's back.
        map[fruta_wx][fruta_wy] = c_cell_snake;
        n = 0;
        while (fruta_valid && n < 6) begin
            tick();
            n++;
        end
        check("inval_valid", int'(fruta_valid), 0);
        check("inval_latency_ok", int'(n >= 1 && n <= 3), 1);
        run_search(2, "inval");

        fill_map(c_cell_snake);
        map[39][29] = c_cell_empty;
        run_search(1, "scan_last");
        check("scan_last_x", int'(fruta_wx), 39);
        check("scan_last_y", int'(fruta_wy), 29);

        fill_map(c_cell_obstacle);
        run_search(1, "full");
        check("full_flag", int'(fruta_full), 1);
        map[5][5] = c_cell_empty;
        run_search(1, "after_full");
        check("after_full_x", int'(fruta_wx), 5);
        check("after_full_y", int'(fruta_wy), 5);

        // Reset landing in SCAN_CHECK.
        fill_map(c_cell_obstacle);
        fruta_enable = 1'b1;
        tick();
        fruta_enable = 1'b0;
        base = occ_total;
        n = 0;
        while ((occ_total - base) <= 80 && n < 3000) begin
            tick();
            n++;
        end
        n = 0;
        while (!fruta_renable && n < 10) begin
            tick();
            n++;
        end
        check("scan_reached", int'(fruta_renable), 1);
        tick();
        reset = 1'b1;
        tick();
        check("midscan_rst_wx", int'(fruta_wx), 13);
        check("midscan_rst_wy", int'(fruta_wy), 13);
        check("midscan_rst_full", int'(fruta_full), 0);
        check("midscan_rst_valid", int'(fruta_valid), 0);
        check("midscan_rst_renable", int'(fruta_renable), 0);
        check("midscan_rst_rx", int'(fruta_rx), 0);
        check("midscan_rst_ry", int'(fruta_ry), 0);
        fill_map(c_cell_empty);
        m_lfsr  = c_lfsr_seed;
        m_tries = 0;
        run_search(0, "after_reset");
        check("lfsr_restart_x", int'(fruta_wx), first_x);
        check("lfsr_restart_y", int'(fruta_wy), first_y);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
